// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, reduction constant and GF(2^8) helpers.
// The forward and inverse MixColumns datapaths use the same reduction constant.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mixState_e;

    // Multiply by x in GF(2^8); poly is the reduction constant applied on MSB overflow
    function automatic logic [7:0] xtime(input logic [7:0] x, input logic [7:0] poly);
        return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x, input logic [7:0] poly);
        return xtime(x, poly) ^ x;
    endfunction

endpackage

// File: rtl/aes_mix_columns_seq_if.sv
// Input and output valid/ready handshakes of the sequential MixColumns engine.
interface aes_mix_columns_seq_if #(
    parameter int unsigned COLS = 4
);
    logic                   InValid;
    logic                   InReady;
    logic [32*COLS-1:0]     InState;
    logic                   OutValid;
    logic                   OutReady;
    logic [32*COLS-1:0]     OutState;
    logic                   Busy;

    modport master (
        output InValid, InState, OutReady,
        input  InReady, OutValid, OutState, Busy
    );

    modport slave (
        input  InValid, InState, OutReady,
        output InReady, OutValid, OutState, Busy
    );
endinterface

// File: rtl/aes_mix_single_column.sv
// Combinational forward MixColumns of one 32-bit column; row 0 is the top byte.
module aes_mix_single_column
    import aes_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY
) (
    input  logic [31:0] colIn,
    output logic [31:0] colOut
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    assign a0 = colIn[31:24];
    assign a1 = colIn[23:16];
    assign a2 = colIn[15:8];
    assign a3 = colIn[7:0];

    assign b0 = xtime(a0, POLY) ^ mul3(a1, POLY) ^ a2 ^ a3;
    assign b1 = a0 ^ xtime(a1, POLY) ^ mul3(a2, POLY) ^ a3;
    assign b2 = a0 ^ a1 ^ xtime(a2, POLY) ^ mul3(a3, POLY);
    assign b3 = mul3(a0, POLY) ^ a1 ^ a2 ^ xtime(a3, POLY);

    assign colOut = {b0, b1, b2, b3};

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Sequential forward MixColumns: accepts a state, rewrites one column per clock in
// place, then holds the result until the downstream takes it.
module aes_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS = 4,
    parameter logic [7:0]  POLY = AES_POLY
) (
    input  logic                  Clk,
    input  logic                  Rst,
    aes_mix_columns_seq_if.slave  bus
);

    localparam int unsigned W    = 32 * COLS;
    localparam int unsigned CntW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CntW-1:0] LastCol = CntW'(COLS - 1);

    mixState_e        stateQ, stateD;
    logic [CntW-1:0]  cntQ, cntD;
    logic [W-1:0]     workQ, workD;
    logic [31:0]      colIn, colOut;

    // Single column unit shared across all columns via the counter mux
    assign colIn = workQ[W-1-32*int'(cntQ) -: 32];

    aes_mix_single_column #(
        .POLY   (POLY)
    ) uColumn (
        .colIn  (colIn),
        .colOut (colOut)
    );

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        workD  = workQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.InValid) begin
                    workD  = bus.InState;
                    cntD   = '0;
                    stateD = StBusy;
                end
            end
            StBusy: begin
                workD[W-1-32*int'(cntQ) -: 32] = colOut;
                if (cntQ == LastCol) begin
                    cntD   = '0;
                    stateD = StDone;
                end else begin
                    cntD = cntQ + CntW'(1);
                end
            end
            StDone: begin
                if (bus.OutReady) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            workQ  <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            workQ  <= workD;
        end
    end

    // Outputs decode state only, so there is no combinational in-to-out path
    assign bus.InReady  = (stateQ == StIdle);
    assign bus.OutValid = (stateQ == StDone);
    assign bus.OutState = (stateQ == StDone) ? workQ : '0;
    assign bus.Busy     = (stateQ != StIdle);

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Self-checking bench for aes_mix_columns_seq against a matrix-product GF(2^8) model.
module tb_aes_mix_columns_seq;

    logic Clk = 1'b0;
    logic Rst;
    int   cyc = 0;
    int   nTests = 0;
    int   nFails = 0;

    aes_mix_columns_seq_if #(.COLS(4)) bus ();

    aes_mix_columns_seq #(
        .COLS (4),
        .POLY (8'h1B)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Generic GF(2^8) product modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // State times the circulant matrix [2 3 1 1], column by column
    function automatic logic [127:0] refMix(input logic [127:0] st);
        logic [7:0]   coef [4] = '{8'd2, 8'd3, 8'd1, 8'd1};
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = st[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gfMul(coef[(k - r + 4) % 4], a[k]);
                res[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge
    task automatic sendState(input logic [127:0] st, input bit keep, output int accCyc);
        bit got = 1'b0;
        accCyc = -1;
        bus.InValid = 1'b1;
        bus.InState = st;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.InReady) begin
                got = 1'b1;
                accCyc = cyc;
            end
            @(negedge Clk);
        end
        checkVal("accept", 128'(got), 128'd1);
        if (!keep) begin
            bus.InValid = 1'b0;
            bus.InState = rand128();
        end
    endtask

    task automatic waitResult(output logic [127:0] res, output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge Clk);
            lat++;
            if (bus.OutValid) got = 1'b1;
        end
        checkVal("result arrives", 128'(got), 128'd1);
        res = bus.OutState;
    endtask

    task automatic runCheck(input string tag, input logic [127:0] st, input logic [127:0] exp);
        logic [127:0] res;
        int           lat;
        int           acc;
        sendState(st, 1'b0, acc);
        waitResult(res, lat);
        checkVal({tag, " latency"}, 128'(lat), 128'd4);
        checkVal(tag, res, exp);
        @(negedge Clk);
        checkVal({tag, " drained"}, 128'(bus.OutValid), 128'd0);
        checkVal({tag, " ready again"}, 128'(bus.InReady), 128'd1);
    endtask

    initial begin
        logic [127:0] a, b, res;
        logic [127:0] s [3];
        int           acc [3];
        int           lat;
        int           dummy;

        Rst          = 1'b1;
        bus.InValid  = 1'b0;
        bus.InState  = '0;
        bus.OutReady = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkVal("reset OutValid", 128'(bus.OutValid), 128'd0);
        checkVal("reset InReady", 128'(bus.InReady), 128'd1);
        checkVal("reset OutState", bus.OutState, 128'd0);
        checkVal("reset Busy", 128'(bus.Busy), 128'd0);
        Rst = 1'b0;

        runCheck("vector1", 128'hdb135345_f20a225c_01010101_2d26314c,
                 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
        runCheck("fips round1", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
                 128'h046681e5_e0cb199a_48f8d37a_2806264c);
        runCheck("fixed c6", 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6,
                 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6);
        runCheck("reduction cols", 128'hc6c6c6c6_d4d4d4d5_80808080_80000000,
                 128'hc6c6c6c6_d5d5d7d6_80808080_1b80809b);
        for (int i = 0; i < 4; i++) begin
            a = rand128();
            runCheck("random", a, refMix(a));
        end

        // Backpressure: result held, new input ignored until drained
        a = rand128();
        b = rand128();
        bus.OutReady = 1'b0;
        sendState(a, 1'b0, dummy);
        waitResult(res, lat);
        checkVal("bp latency", 128'(lat), 128'd4);
        checkVal("bp result", res, refMix(a));
        bus.InValid = 1'b1;
        bus.InState = b;
        repeat (10) begin
            @(negedge Clk);
            checkVal("bp OutValid held", 128'(bus.OutValid), 128'd1);
            checkVal("bp OutState held", bus.OutState, refMix(a));
            checkVal("bp InReady low", 128'(bus.InReady), 128'd0);
        end
        bus.OutReady = 1'b1;
        sendState(b, 1'b0, dummy);
        waitResult(res, lat);
        checkVal("bp second result", res, refMix(b));
        @(negedge Clk);

        // Reset on the second BUSY cycle discards the in-flight state
        sendState(rand128(), 1'b0, dummy);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        checkVal("midreset OutValid", 128'(bus.OutValid), 128'd0);
        checkVal("midreset InReady", 128'(bus.InReady), 128'd1);
        checkVal("midreset OutState", bus.OutState, 128'd0);
        checkVal("midreset Busy", 128'(bus.Busy), 128'd0);
        bus.InValid = 1'b1;
        bus.InState = rand128();
        @(negedge Clk);
        checkVal("reset beats InValid", 128'(bus.Busy), 128'd0);
        Rst = 1'b0;
        bus.InValid = 1'b0;
        a = rand128();
        runCheck("after reset", a, refMix(a));

        // Streaming with InValid held high: accepts every 6 cycles, results in order
        for (int k = 0; k < 3; k++) s[k] = rand128();
        for (int k = 0; k < 3; k++) begin
            sendState(s[k], 1'b1, acc[k]);
            waitResult(res, lat);
            checkVal("stream latency", 128'(lat), 128'd4);
            checkVal("stream result", res, refMix(s[k]));
        end
        bus.InValid = 1'b0;
        checkVal("stream spacing 0-1", 128'(acc[1] - acc[0]), 128'd6);
        checkVal("stream spacing 1-2", 128'(acc[2] - acc[1]), 128'd6);
        repeat (2) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", nTests, nFails);
        $finish;
    end

endmodule
